// File: rtl/neonfox_pkg.sv
// Shared definitions for the fetch-side pipeline: address width default, reset vector
// and the program-counter next-address select encoding.
package neonfox_pkg;

  localparam int ADDR_W_DEF = 16;
  localparam logic [15:0] RESET_VECTOR_DEF = 16'h0000;

  typedef enum logic [1:0] {
    PC_HOLD   = 2'd0,
    PC_INC    = 2'd1,
    PC_TARGET = 2'd2,
    PC_POP    = 2'd3
  } pc_sel_t;

endpackage

// File: rtl/pc_unit_if.sv
// Control-in / fetch-out bundle between decode_unit, hazard logic and pc_unit.
interface pc_unit_if
  import neonfox_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF
);
  logic              hazard;
  logic              p_cache_miss;
  logic              pc_jmp;
  logic              pc_brx;
  logic              pc_brxt;
  logic              pc_call;
  logic              pc_ret;
  logic              cond_flag;
  logic [ADDR_W-1:0] target_addr;
  logic [ADDR_W-1:0] p_addr;
  logic              redirect;
  logic              stack_ovf;
  logic              stack_unf;

  modport master (
    output hazard, p_cache_miss, pc_jmp, pc_brx, pc_brxt, pc_call, pc_ret,
    output cond_flag, target_addr,
    input  p_addr, redirect, stack_ovf, stack_unf
  );

  modport slave (
    input  hazard, p_cache_miss, pc_jmp, pc_brx, pc_brxt, pc_call, pc_ret,
    input  cond_flag, target_addr,
    output p_addr, redirect, stack_ovf, stack_unf
  );
endinterface

// File: rtl/pc_unit_ret_stack.sv
// Return-address LIFO kept as a circular buffer so a push while full silently
// replaces the oldest entry; overflow/underflow are sticky until reset.
module ret_stack
  import neonfox_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DEPTH  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              push,
  input  logic              pop,
  input  logic [ADDR_W-1:0] push_data,
  output logic [ADDR_W-1:0] top_data,
  output logic              empty,
  output logic              ovf,
  output logic              unf
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int SP_W  = PTR_W + 1;

  logic [ADDR_W-1:0] mem_r [DEPTH];
  logic [PTR_W-1:0]  wr_ptr_r;
  logic [SP_W-1:0]   sp_r;
  logic              full_s;

  assign full_s   = (sp_r == SP_W'(DEPTH));
  assign empty    = (sp_r == {SP_W{1'b0}});
  assign top_data = mem_r[wr_ptr_r - PTR_W'(1)];

  // Write pointer, occupancy and sticky error flags
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_r <= {PTR_W{1'b0}};
      sp_r     <= {SP_W{1'b0}};
      ovf      <= 1'b0;
      unf      <= 1'b0;
    end else if (push) begin
      wr_ptr_r <= wr_ptr_r + PTR_W'(1);
      if (full_s) begin
        ovf <= 1'b1;
      end else begin
        sp_r <= sp_r + SP_W'(1);
      end
    end else if (pop) begin
      if (empty) begin
        unf <= 1'b1;
      end else begin
        wr_ptr_r <= wr_ptr_r - PTR_W'(1);
        sp_r     <= sp_r - SP_W'(1);
      end
    end
  end

  // Entry storage; contents are don't-care out of reset
  always_ff @(posedge clk) begin
    if (push) begin
      mem_r[wr_ptr_r] <= push_data;
    end
  end

endmodule

// File: rtl/pc_unit.sv
// Program counter and call/return redirection feeding the program cache.
// Taken transfers are not flushed: already-fetched words run as delay slots.
module pc_unit
  import neonfox_pkg::*;
#(
  parameter int              ADDR_W       = ADDR_W_DEF,
  parameter int              STACK_DEPTH  = 16,
  parameter logic [ADDR_W-1:0] RESET_VECTOR = ADDR_W'(RESET_VECTOR_DEF)
) (
  input logic        clk,
  input logic        rst_n,
  pc_unit_if.slave   bus
);

  logic [ADDR_W-1:0] p_addr_r;
  logic [ADDR_W-1:0] next_addr_s;
  logic [ADDR_W-1:0] top_data_s;
  logic              redirect_r;
  logic              consumed_r;
  logic              stall_s;
  logic              taken_s;
  logic              act_s;
  logic              push_s;
  logic              pop_s;
  logic              empty_s;
  logic              ovf_s;
  logic              unf_s;
  pc_sel_t           sel_s;

  assign stall_s = bus.hazard | bus.p_cache_miss;
  assign taken_s = bus.pc_jmp | bus.pc_call | bus.pc_ret |
                   (bus.pc_brx & (bus.cond_flag == bus.pc_brxt));
  // decode holds its controls through a hazard, so only the first edge may act
  assign act_s   = ~consumed_r & taken_s;

  // Priority select: ret > call > jmp/brx > increment > hold
  always_comb begin
    sel_s  = PC_HOLD;
    push_s = 1'b0;
    pop_s  = 1'b0;
    if (act_s && bus.pc_ret) begin
      sel_s = PC_POP;
      pop_s = 1'b1;
    end else if (act_s && bus.pc_call) begin
      sel_s  = PC_TARGET;
      push_s = 1'b1;
    end else if (act_s) begin
      sel_s = PC_TARGET;
    end else if (!stall_s) begin
      sel_s = PC_INC;
    end else begin
      sel_s = PC_HOLD;
    end
  end

  // Next fetch address from the selected source
  always_comb begin
    next_addr_s = p_addr_r;
    case (sel_s)
      PC_INC:    next_addr_s = p_addr_r + ADDR_W'(1);
      PC_TARGET: next_addr_s = bus.target_addr;
      PC_POP: begin
        if (empty_s) begin
          next_addr_s = RESET_VECTOR;
        end else begin
          next_addr_s = top_data_s;
        end
      end
      PC_HOLD:   next_addr_s = p_addr_r;
      default:   next_addr_s = p_addr_r;
    endcase
  end

  // PC register, redirect pulse and single-action tracking
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      p_addr_r   <= RESET_VECTOR;
      redirect_r <= 1'b0;
      consumed_r <= 1'b0;
    end else begin
      p_addr_r   <= next_addr_s;
      redirect_r <= act_s;
      if (!bus.hazard) begin
        consumed_r <= 1'b0;
      end else if (act_s) begin
        consumed_r <= 1'b1;
      end
    end
  end

  ret_stack #(
    .ADDR_W (ADDR_W),
    .DEPTH  (STACK_DEPTH)
  ) u_ret_stack (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (push_s),
    .pop       (pop_s),
    .push_data (p_addr_r),
    .top_data  (top_data_s),
    .empty     (empty_s),
    .ovf       (ovf_s),
    .unf       (unf_s)
  );

  assign bus.p_addr    = p_addr_r;
  assign bus.redirect  = redirect_r;
  assign bus.stack_ovf = ovf_s;
  assign bus.stack_unf = unf_s;

endmodule
